// File: rtl/pe_frame_loader.sv
// Input staging FIFO for pe: buffers complex samples and replays each complete
// X/Y operand frame as one gap-free burst, followed by a fixed idle gap.
module pe_frame_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [2*DATA_WIDTH-1:0]       s_data,
  output logic                          s_ready,
  output logic                          dout_pe_v,
  output logic [2*DATA_WIDTH-1:0]       dout_pe,
  output logic                          dout_sel,
  output logic                          dout_last,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = 2 * DATA_WIDTH;
  localparam int FW = 2 * FRAME_LEN;
  localparam int CW = $clog2(FW + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [AW:0]   FRAME_WORDS = (AW + 1)'(FW);
  localparam logic [AW:0]   DEPTH       = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] X_WORDS     = CW'(FRAME_LEN);
  localparam logic [CW-1:0] ALL_WORDS   = CW'(FW);
  localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP_CYCLES);

  if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < FW) || (GAP_CYCLES < 1)) begin : g_bad_params
    $error("pe_frame_loader: FIFO_DEPTH must be a power of 2 >= 2*FRAME_LEN and GAP_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD_X, LOAD_Y, GAP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   wcnt, wcnt_next;
  logic [GW-1:0]   gcnt, gcnt_next;
  logic            push, pop, frame_ready;
  logic [WW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  assign s_ready     = fifo_count < DEPTH;
  assign push        = s_valid & s_ready;
  assign frame_ready = fifo_count >= FRAME_WORDS;
  assign busy        = state != IDLE;

  // wcnt_next is the 1-based position of the word popped this cycle, so it
  // directly decides that word's sel/last flags and the following state.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    gcnt_next  = gcnt;
    pop        = 1'b0;
    unique case (state)
      IDLE:   pop = frame_ready;
      LOAD_X,
      LOAD_Y: pop = 1'b1;
      GAP: begin
        if (gcnt == '0) begin
          if (frame_ready) pop = 1'b1;
          else             state_next = IDLE;
        end else begin
          gcnt_next = gcnt - GW'(1);
        end
      end
    endcase
    if (pop) begin
      wcnt_next = (state == LOAD_X || state == LOAD_Y) ? wcnt + CW'(1) : CW'(1);
      if (wcnt_next == ALL_WORDS) begin
        state_next = GAP;
        gcnt_next  = GAP_LOAD;
      end else if (wcnt_next >= X_WORDS) begin
        state_next = LOAD_Y;
      end else begin
        state_next = LOAD_X;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      gcnt  <= gcnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + (AW + 1)'(1);
      else if (pop && !push) fifo_count <= fifo_count - (AW + 1)'(1);
    end
  end

  // Outputs are zeroed whenever no word is being presented to pe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_pe_v <= 1'b0;
      dout_pe   <= '0;
      dout_sel  <= 1'b0;
      dout_last <= 1'b0;
    end else begin
      dout_pe_v <= pop;
      dout_pe   <= pop ? mem[rd_ptr] : '0;
      dout_sel  <= pop && (wcnt_next > X_WORDS);
      dout_last <= pop && (wcnt_next == ALL_WORDS);
    end
  end

endmodule
